// File: rtl/dff_q_debounce.sv
// Debounces the q output of an upstream dff_async_rst. A level change is
// accepted only after it has been stable for STABLE_CYCLES enabled clocks.
module dff_q_debounce #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 16,
  parameter logic        INIT_VAL      = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d_in,
  input  logic             count_clr,
  output logic             q_stable,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             glitch,
  output logic [CNT_W-1:0] edge_count,
  output logic             busy
);

  localparam int unsigned          CntW    = $clog2(STABLE_CYCLES);
  localparam logic [CntW-1:0]      CntLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     EdgeMax = '1;

  typedef enum logic {StStable, StChecking} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             q_stable_d;
  logic             rise_d, fall_d, glitch_d;
  logic [CNT_W-1:0] edge_count_d;
  logic             accept;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    q_stable_d   = q_stable;
    rise_d       = 1'b0;
    fall_d       = 1'b0;
    glitch_d     = 1'b0;
    edge_count_d = edge_count;
    accept       = 1'b0;

    if (en) begin
      unique case (state_q)
        StStable: begin
          if (d_in != q_stable) begin
            state_d = StChecking;
            cnt_d   = CntW'(1);
          end
        end
        StChecking: begin
          if (d_in == q_stable) begin
            state_d  = StStable;
            cnt_d    = '0;
            glitch_d = 1'b1;
          end else if (cnt_q == CntLast) begin
            state_d    = StStable;
            cnt_d      = '0;
            q_stable_d = d_in;
            rise_d     = d_in;
            fall_d     = ~d_in;
            accept     = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Clear first, then count, so a coincident accept leaves the counter at 1.
    if (count_clr) begin
      edge_count_d = '0;
    end
    if (accept && (edge_count_d != EdgeMax)) begin
      edge_count_d = edge_count_d + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StStable;
      cnt_q      <= '0;
      q_stable   <= INIT_VAL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      glitch     <= 1'b0;
      edge_count <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      q_stable   <= q_stable_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
      glitch     <= glitch_d;
      edge_count <= edge_count_d;
    end
  end

  // state_q is a flop, so busy is still a registered output.
  assign busy = (state_q == StChecking);

endmodule

// File: tb/tb_dff_q_debounce.sv
// Directed bench for dff_q_debounce: default instance plus a CNT_W=2 instance
// for counter saturation.
module tb_dff_q_debounce;

  logic        clk;
  logic        rst, en, d_in, count_clr;
  logic        q_stable, rise_pulse, fall_pulse, glitch, busy;
  logic [15:0] edge_count;

  logic        rst2, d2;
  logic        q2, rise2, fall2, glitch2, busy2;
  logic [1:0]  ec2;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  dff_q_debounce #(
    .STABLE_CYCLES(4),
    .CNT_W        (16),
    .INIT_VAL     (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .d_in      (d_in),
    .count_clr (count_clr),
    .q_stable  (q_stable),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .glitch    (glitch),
    .edge_count(edge_count),
    .busy      (busy)
  );

  dff_q_debounce #(
    .STABLE_CYCLES(4),
    .CNT_W        (2),
    .INIT_VAL     (1'b0)
  ) dut_sat (
    .clk       (clk),
    .rst       (rst2),
    .en        (en),
    .d_in      (d2),
    .count_clr (count_clr),
    .q_stable  (q2),
    .rise_pulse(rise2),
    .fall_pulse(fall2),
    .glitch    (glitch2),
    .edge_count(ec2),
    .busy      (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic q, input logic r, input logic f,
                            input logic g, input logic b, input logic [15:0] ec);
    chk({tag, ".q_stable"},   32'(q_stable),   32'(q));
    chk({tag, ".rise"},       32'(rise_pulse), 32'(r));
    chk({tag, ".fall"},       32'(fall_pulse), 32'(f));
    chk({tag, ".glitch"},     32'(glitch),     32'(g));
    chk({tag, ".busy"},       32'(busy),       32'(b));
    chk({tag, ".edge_count"}, 32'(edge_count), 32'(ec));
  endtask

  initial begin
    rst = 1'b0; rst2 = 1'b0; en = 1'b1; d_in = 1'b1; count_clr = 1'b0; d2 = 1'b0;
    #3;
    expect_all("reset_t0", 0, 0, 0, 0, 0, 16'd0);
    step();
    step();
    expect_all("reset_clk", 0, 0, 0, 0, 0, 16'd0);

    // Release with d_in=1 held: busy at edge 1, accept at edge 4.
    rst = 1'b1; rst2 = 1'b1;
    step();
    expect_all("rel_e1", 0, 0, 0, 0, 1, 16'd0);
    step();
    step();
    expect_all("rel_e3", 0, 0, 0, 0, 1, 16'd0);
    step();
    expect_all("rel_e4", 1, 1, 0, 0, 0, 16'd1);
    step();
    expect_all("rel_e5", 1, 0, 0, 0, 0, 16'd1);

    d_in = 1'b0;
    step(); step(); step();
    expect_all("fall_e3", 1, 0, 0, 0, 1, 16'd1);
    step();
    expect_all("fall_e4", 0, 0, 1, 0, 0, 16'd2);
    step();
    expect_all("fall_e5", 0, 0, 0, 0, 0, 16'd2);

    // Glitch: two edges high, then back low.
    d_in = 1'b1;
    step(); step();
    d_in = 1'b0;
    step();
    expect_all("glitch_e3", 0, 0, 0, 1, 0, 16'd2);
    step();
    expect_all("glitch_e4", 0, 0, 0, 0, 0, 16'd2);

    // Enable pattern 1,0,0,1,1,1.
    d_in = 1'b1;
    step();
    en = 1'b0;
    step(); step();
    expect_all("en_off", 0, 0, 0, 0, 1, 16'd2);
    en = 1'b1;
    step(); step();
    expect_all("en_e5", 0, 0, 0, 0, 1, 16'd2);
    step();
    expect_all("en_e6", 1, 1, 0, 0, 0, 16'd3);

    d_in = 1'b0;
    step(); step(); step(); step();
    expect_all("build_fall", 0, 0, 1, 0, 0, 16'd4);
    d_in = 1'b1;
    step(); step(); step(); step();
    expect_all("build_rise", 1, 1, 0, 0, 0, 16'd5);

    // Fall with count_clr on the accepting edge.
    d_in = 1'b0;
    step(); step(); step();
    count_clr = 1'b1;
    step();
    expect_all("clr_accept", 0, 0, 1, 0, 0, 16'd1);
    count_clr = 1'b0;
    step();
    expect_all("clr_after", 0, 0, 0, 0, 0, 16'd1);

    // Async reset mid-check.
    d_in = 1'b1;
    step(); step();
    chk("mid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    expect_all("async_rst", 0, 0, 0, 0, 0, 16'd0);
    d_in = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_all("post_rst", 0, 0, 0, 0, 0, 16'd0);
    end

    // Saturation on the CNT_W=2 instance: counts 1,2,3,3,3.
    for (int i = 0; i < 5; i++) begin
      d2 = ~d2;
      step(); step(); step();
      chk("sat_nopulse", 32'({rise2, fall2}), 32'd0);
      step();
      chk("sat_q", 32'(q2), 32'(d2));
      chk("sat_pulse", 32'({rise2, fall2}), d2 ? 32'd2 : 32'd1);
      chk("sat_count", 32'(ec2), (i < 3) ? 32'(i + 1) : 32'd3);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
